// File: rtl/ctrl_pkt_buffer.sv
// Packet-atomic control-path buffer: absorbs every incoming beat, releases only whole
// committed packets over AXI-Stream, and drops (and counts) packets that do not fit.
//
// Handshake: a beat moves on m_axis in exactly the cycle where m_axis_tvalid and
// m_axis_tready are both high at the rising edge. Once tvalid is high, the output
// holds it and all payload stable until that handshake. s_axis has no ready, so every
// cycle with s_axis_tvalid high delivers a beat.
module ctrl_pkt_buffer #(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int ADDR_WIDTH           = 4
) (
   input  logic                                clk,
   input  logic                                aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic                                s_axis_tvalid,
   input  logic                                s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic                                m_axis_tlast,
   output logic [ADDR_WIDTH:0]                 pkt_cnt,
   output logic [31:0]                         drop_cnt,
   output logic [1:0]                          wr_state_o
);

   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW    = C_S_AXIS_TUSER_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] PTR_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      DISCARD = 2'd2
   } wr_state_e;

   wr_state_e               state_q, state_d;
   logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]     commit_ptr_q, commit_ptr_d;
   logic [ADDR_WIDTH:0]     rd_ptr_q;
   logic [31:0]             drop_cnt_q, drop_cnt_d;
   logic [ADDR_WIDTH:0]     pkt_cnt_q;

   logic [DW-1:0]           mem_data [DEPTH];
   logic [KW-1:0]           mem_keep [DEPTH];
   logic [UW-1:0]           mem_user [DEPTH];
   logic                    mem_last [DEPTH];

   logic [DW-1:0]           out_data_q;
   logic [KW-1:0]           out_keep_q;
   logic [UW-1:0]           out_user_q;
   logic                    out_last_q;
   logic                    out_valid_q;

   logic                    full;
   logic                    readable;
   logic                    load;
   logic                    store;
   logic                    commit;
   logic                    out_last_hs;

   // Full uses the pre-read rd_ptr, so a same-cycle read never frees space for this write.
   assign full        = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
   assign readable    = rd_ptr_q != commit_ptr_q;
   assign load        = readable && (!out_valid_q || m_axis_tready);
   assign out_last_hs = out_valid_q && m_axis_tready && out_last_q;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      drop_cnt_d   = drop_cnt_q;
      store        = 1'b0;
      commit       = 1'b0;
      case (state_q)
         IDLE, WRITE: begin
            if (s_axis_tvalid) begin
               if (!full) begin
                  store    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (s_axis_tlast) begin
                     commit       = 1'b1;
                     commit_ptr_d = wr_ptr_q + PTR_ONE;
                     state_d      = IDLE;
                  end else begin
                     state_d = WRITE;
                  end
               end else begin
                  // Rolling back is a no-op from IDLE, where wr_ptr already equals commit_ptr.
                  wr_ptr_d = commit_ptr_q;
                  if (s_axis_tlast) begin
                     drop_cnt_d = drop_cnt_q + 32'd1;
                     state_d    = IDLE;
                  end else begin
                     state_d = DISCARD;
                  end
               end
            end
         end
         DISCARD: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               drop_cnt_d = drop_cnt_q + 32'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (store) begin
         mem_data[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
         mem_keep[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tkeep;
         mem_user[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tuser;
         mem_last[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tlast;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_user_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (load) begin
         rd_ptr_q    <= rd_ptr_q + PTR_ONE;
         out_valid_q <= 1'b1;
         out_data_q  <= mem_data[rd_ptr_q[ADDR_WIDTH-1:0]];
         out_keep_q  <= mem_keep[rd_ptr_q[ADDR_WIDTH-1:0]];
         out_user_q  <= mem_user[rd_ptr_q[ADDR_WIDTH-1:0]];
         out_last_q  <= mem_last[rd_ptr_q[ADDR_WIDTH-1:0]];
      end else if (out_valid_q && m_axis_tready) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_cnt_q <= '0;
      end else if (commit && !out_last_hs) begin
         pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
      end else if (!commit && out_last_hs) begin
         pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
      end
   end

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tuser  = out_user_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tvalid = out_valid_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign drop_cnt      = drop_cnt_q;
   assign wr_state_o    = state_q;

endmodule

// File: tb/tb_ctrl_pkt_buffer.sv
// Directed bench for ctrl_pkt_buffer: beats carry a 16-bit tag replicated across
// tdata/tkeep/tuser, and delivered beats are collected and compared to expected tags.
module tb_ctrl_pkt_buffer;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int UW = 128;
   localparam int AW = 4;

   logic              clk = 1'b0;
   logic              aresetn = 1'b0;
   logic [DW-1:0]     s_axis_tdata = '0;
   logic [KW-1:0]     s_axis_tkeep = '0;
   logic [UW-1:0]     s_axis_tuser = '0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tlast = 1'b0;
   logic [DW-1:0]     m_axis_tdata;
   logic [KW-1:0]     m_axis_tkeep;
   logic [UW-1:0]     m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b0;
   logic              m_axis_tlast;
   logic [AW:0]       pkt_cnt;
   logic [31:0]       drop_cnt;
   logic [1:0]        wr_state_o;

   ctrl_pkt_buffer #(
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_TUSER_WIDTH(UW),
      .ADDR_WIDTH          (AW)
   ) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .pkt_cnt      (pkt_cnt),
      .drop_cnt     (drop_cnt),
      .wr_state_o   (wr_state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // scoreboard: {tlast, tag} of expected and delivered beats
   logic [16:0] exp_q[$];
   logic [16:0] got_q[$];
   int          stab_viol;
   int          fmt_viol;
   int          valid_seen;
   logic        prev_stall;
   logic [DW+KW+UW:0] prev_out;

   task automatic do_reset();
      @(negedge clk);
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      m_axis_tready = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      exp_q.delete();
      got_q.delete();
      stab_viol  = 0;
      fmt_viol   = 0;
      valid_seen = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
   endtask

   // Driver: one cycle. Inputs change at the falling edge; outputs are sampled 1 ns later
   // and a beat is recorded when it will handshake at the coming rising edge.
   task automatic tick(input logic v, input logic last, input logic [15:0] tag, input logic rdy);
      @(negedge clk);
      s_axis_tvalid = v;
      s_axis_tlast  = v & last;
      s_axis_tdata  = v ? {32{tag}} : '0;
      s_axis_tkeep  = v ? {4{tag}} : '0;
      s_axis_tuser  = v ? {8{tag}} : '0;
      m_axis_tready = rdy;
      #1;
      if (prev_stall && (!m_axis_tvalid ||
          {m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser} != prev_out))
         stab_viol++;
      if (m_axis_tvalid) begin
         valid_seen++;
         if (m_axis_tdata != {32{m_axis_tdata[15:0]}} || m_axis_tkeep != {4{m_axis_tdata[15:0]}} ||
             m_axis_tuser != {8{m_axis_tdata[15:0]}})
            fmt_viol++;
         if (rdy) got_q.push_back({m_axis_tlast, m_axis_tdata[15:0]});
      end
      prev_stall = m_axis_tvalid && !rdy;
      prev_out   = {m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser};
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) tick(1'b0, 1'b0, 16'h0, rdy);
   endtask

   task automatic send_pkt(input logic [15:0] base, input int len, input logic rdy, input logic expect_out);
      for (int i = 0; i < len; i++) begin
         tick(1'b1, i == len - 1, 16'(base + i), rdy);
         if (expect_out) exp_q.push_back({i == len - 1, 16'(base + i)});
      end
   endtask

   // Index of first differing entry, -2 on size difference, -1 when identical.
   function automatic int first_diff();
      if (got_q.size() != exp_q.size()) return -2;
      for (int i = 0; i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      do_reset();
      tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
      tests_run++; if (m_axis_tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata: got %0h expected 0", m_axis_tdata[31:0]); end
      tests_run++; if (m_axis_tkeep !== '0) begin tests_failed++; $display("FAIL reset_tkeep: got %0h expected 0", m_axis_tkeep); end
      tests_run++; if (m_axis_tuser !== '0) begin tests_failed++; $display("FAIL reset_tuser: got %0h expected 0", m_axis_tuser); end
      tests_run++; if (m_axis_tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %0b expected 0", m_axis_tlast); end
      tests_run++; if (pkt_cnt !== '0) begin tests_failed++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
      tests_run++; if (drop_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
      tests_run++; if (wr_state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", wr_state_o); end
   endtask

   task automatic test_single_pkt();
      int d;
      do_reset();
      send_pkt(16'h0100, 3, 1'b1, 1'b1);
      tests_run++; if (pkt_cnt !== 5'd0) begin tests_failed++; $display("FAIL single_pre_commit_cnt: got %0d expected 0", pkt_cnt); end
      idle(1, 1'b1);
      tests_run++; if (pkt_cnt !== 5'd1) begin tests_failed++; $display("FAIL single_commit_cnt: got %0d expected 1", pkt_cnt); end
      tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid: got %0b expected 0", m_axis_tvalid); end
      idle(1, 1'b1);
      tests_run++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h0100) begin
         tests_failed++; $display("FAIL single_latency: got valid %0b tag %0h expected 1 0100", m_axis_tvalid, m_axis_tdata[15:0]); end
      idle(5, 1'b1);
      d = first_diff();
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL single_order: got diff at %0d (size %0d) expected none (size %0d)", d, got_q.size(), exp_q.size()); end
      tests_run++; if (pkt_cnt !== 5'd0) begin tests_failed++; $display("FAIL single_final_cnt: got %0d expected 0", pkt_cnt); end
      tests_run++; if (drop_cnt !== 32'd0 || fmt_viol != 0) begin tests_failed++; $display("FAIL single_drop_fmt: got drop %0d fmt %0d expected 0 0", drop_cnt, fmt_viol); end
   endtask

   task automatic test_fill_drop();
      int d;
      do_reset();
      for (int p = 0; p < 4; p++) send_pkt(16'(16'h0200 + 16 * p), 4, 1'b0, 1'b1);
      idle(2, 1'b0);
      tests_run++; if (pkt_cnt !== 5'd4) begin tests_failed++; $display("FAIL fill_pkt_cnt: got %0d expected 4", pkt_cnt); end
      send_pkt(16'h0280, 4, 1'b0, 1'b0);
      idle(1, 1'b0);
      tests_run++; if (drop_cnt !== 32'd1) begin tests_failed++; $display("FAIL fill_drop_cnt: got %0d expected 1", drop_cnt); end
      tests_run++; if (pkt_cnt !== 5'd4) begin tests_failed++; $display("FAIL fill_pkt_cnt_after_drop: got %0d expected 4", pkt_cnt); end
      tests_run++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h0200) begin
         tests_failed++; $display("FAIL fill_head: got valid %0b tag %0h expected 1 0200", m_axis_tvalid, m_axis_tdata[15:0]); end
      idle(24, 1'b1);
      d = first_diff();
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL fill_drain: got diff at %0d (size %0d) expected none (size %0d)", d, got_q.size(), exp_q.size()); end
      tests_run++; if (pkt_cnt !== 5'd0 || stab_viol != 0) begin tests_failed++; $display("FAIL fill_end: got cnt %0d stab %0d expected 0 0", pkt_cnt, stab_viol); end
   endtask

   task automatic test_overflow_rollback();
      int d;
      do_reset();
      send_pkt(16'h0300, 10, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 16'(16'h0310 + i), 1'b0);
      tick(1'b1, 1'b1, 16'h0319, 1'b0);
      tests_run++; if (wr_state_o !== 2'd2) begin tests_failed++; $display("FAIL ovf_discard_state: got %0d expected 2", wr_state_o); end
      idle(1, 1'b0);
      tests_run++; if (drop_cnt !== 32'd1 || wr_state_o !== 2'd0) begin
         tests_failed++; $display("FAIL ovf_drop: got drop %0d state %0d expected 1 0", drop_cnt, wr_state_o); end
      tests_run++; if (pkt_cnt !== 5'd1) begin tests_failed++; $display("FAIL ovf_pkt_cnt: got %0d expected 1", pkt_cnt); end
      idle(16, 1'b1);
      d = first_diff();
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL ovf_output: got diff at %0d (size %0d) expected none (size %0d)", d, got_q.size(), exp_q.size()); end
   endtask

   task automatic test_long_drop();
      int d;
      do_reset();
      send_pkt(16'h0700, 20, 1'b1, 1'b0);
      idle(3, 1'b1);
      tests_run++; if (valid_seen != 0) begin tests_failed++; $display("FAIL long_valid_seen: got %0d expected 0", valid_seen); end
      tests_run++; if (drop_cnt !== 32'd1 || pkt_cnt !== 5'd0) begin
         tests_failed++; $display("FAIL long_counts: got drop %0d cnt %0d expected 1 0", drop_cnt, pkt_cnt); end
      send_pkt(16'h07AA, 1, 1'b1, 1'b1);
      idle(4, 1'b1);
      d = first_diff();
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL long_recover: got diff at %0d (size %0d) expected none (size %0d)", d, got_q.size(), exp_q.size()); end
   endtask

   task automatic test_random_stream();
      int d;
      int zeros;
      logic rdy;
      do_reset();
      zeros = 0;
      for (int i = 0; i < 32; i++) begin
         rdy = ($urandom_range(0, 3) != 0) || (zeros >= 10);
         if (!rdy) zeros++;
         tick(1'b1, 1'b1, 16'(16'h0400 + i), rdy);
         exp_q.push_back({1'b1, 16'(16'h0400 + i)});
      end
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'h0, ($urandom_range(0, 3) != 0) || (i > 10));
      d = first_diff();
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rand_order: got diff at %0d (size %0d) expected none (size %0d)", d, got_q.size(), exp_q.size()); end
      tests_run++; if (stab_viol != 0 || fmt_viol != 0) begin tests_failed++; $display("FAIL rand_stable: got stab %0d fmt %0d expected 0 0", stab_viol, fmt_viol); end
      tests_run++; if (drop_cnt !== 32'd0 || pkt_cnt !== 5'd0) begin
         tests_failed++; $display("FAIL rand_counts: got drop %0d cnt %0d expected 0 0", drop_cnt, pkt_cnt); end
   endtask

   task automatic test_reset_mid();
      int d;
      do_reset();
      send_pkt(16'h0500, 2, 1'b0, 1'b0);
      send_pkt(16'h0510, 2, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 16'h0520, 1'b0);
      tests_run++; if (pkt_cnt !== 5'd2 || m_axis_tvalid !== 1'b1) begin
         tests_failed++; $display("FAIL mid_pre_reset: got cnt %0d valid %0b expected 2 1", pkt_cnt, m_axis_tvalid); end
      @(negedge clk);
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      #1;
      tests_run++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
         tests_failed++; $display("FAIL mid_async_out: got valid %0b tag %0h last %0b expected 0 0 0", m_axis_tvalid, m_axis_tdata[15:0], m_axis_tlast); end
      tests_run++; if (pkt_cnt !== 5'd0 || drop_cnt !== 32'd0) begin
         tests_failed++; $display("FAIL mid_async_cnt: got cnt %0d drop %0d expected 0 0", pkt_cnt, drop_cnt); end
      @(negedge clk);
      aresetn    = 1'b1;
      prev_stall = 1'b0;
      got_q.delete();
      exp_q.delete();
      send_pkt(16'h0600, 2, 1'b1, 1'b1);
      idle(1, 1'b1);
      tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_early_valid: got %0b expected 0", m_axis_tvalid); end
      idle(1, 1'b1);
      tests_run++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata[15:0] !== 16'h0600) begin
         tests_failed++; $display("FAIL mid_latency: got valid %0b tag %0h expected 1 0600", m_axis_tvalid, m_axis_tdata[15:0]); end
      idle(4, 1'b1);
      d = first_diff();
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL mid_output: got diff at %0d (size %0d) expected none (size %0d)", d, got_q.size(), exp_q.size()); end
      tests_run++; if (drop_cnt !== 32'd0) begin tests_failed++; $display("FAIL mid_drop_cnt: got %0d expected 0", drop_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_pkt();
      test_fill_drop();
      test_overflow_rollback();
      test_long_drop();
      test_random_stream();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
